// File: rtl/serial_pattern_detector_param.sv
// Mealy serial pattern detector with run-time loadable pattern, overlap select,
// input-valid qualifier and saturating match counter.
module serial_pattern_detector_param #(
  parameter int unsigned      PAT_W       = 4,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = 4'b1011,
  parameter int unsigned      CNT_W       = 8,
  localparam int unsigned     FILL_W      = $clog2(PAT_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_i,
  input  logic              overlap_en,
  input  logic              pat_load,
  input  logic [PAT_W-1:0]  pat_i,
  input  logic              cnt_clr,
  output logic              detect,
  output logic [CNT_W-1:0]  match_count,
  output logic [FILL_W-1:0] fill_o
);

  generate
    if (PAT_W < 2 || PAT_W > 16) begin : g_bad_pat_w
      $error("serial_pattern_detector_param: PAT_W must be in 2..16");
    end
  endgenerate

  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PAT_W-1:0]  window;
  logic              shift_en;

  // Candidate match: the stored history followed by the bit arriving now.
  assign window   = {hist_q, in_i};
  assign shift_en = in_valid & ~pat_load;
  assign detect   = shift_en & ~rst & (fill_q == FILL_MAX) & (window == pat_q);

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    if (pat_load) begin
      pat_d  = pat_i;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = window[PAT_W-2:0];
      if (detect && !overlap_en) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (detect && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= PAT_DEFAULT;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
    end
  end

  assign match_count = cnt_q;
  assign fill_o      = fill_q;

endmodule

// File: tb/tb_serial_pattern_detector_param.sv
// Bench for serial_pattern_detector_param (PAT_W=4, CNT_W=3): directed scenarios
// plus randomized traffic against a bit-history reference model.
module tb_serial_pattern_detector_param;

  localparam int PAT_W   = 4;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = 7;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_i, overlap_en, pat_load, cnt_clr;
  logic [PAT_W-1:0] pat_i;
  logic             detect;
  logic [CNT_W-1:0] match_count;
  logic [1:0]       fill_o;

  serial_pattern_detector_param #(
    .PAT_W(PAT_W), .PAT_DEFAULT(4'b1011), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_i(in_i),
    .overlap_en(overlap_en), .pat_load(pat_load), .pat_i(pat_i),
    .cnt_clr(cnt_clr), .detect(detect), .match_count(match_count),
    .fill_o(fill_o)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  // Reference model: valid bits seen since the last reset/load/non-overlapping match.
  int         seq[$];
  logic [3:0] m_pat = 4'b1011;
  int         m_cnt = 0;
  logic       obs_det, exp_det;

  function automatic logic model_detect();
    int w;
    if (rst || !in_valid || pat_load || seq.size() < PAT_W - 1) return 1'b0;
    w = 0;
    foreach (seq[k]) w = ((w << 1) | seq[k]) & 7;
    w = (w << 1) | int'(in_i);
    return w == int'(m_pat);
  endfunction

  function automatic void model_edge();
    logic d;
    d = model_detect();
    if (rst) begin
      seq.delete();
      m_pat = 4'b1011;
      m_cnt = 0;
      return;
    end
    if (pat_load) begin
      m_pat = pat_i;
      seq.delete();
    end else if (in_valid) begin
      if (d && !overlap_en) seq.delete();
      else begin
        seq.push_back(int'(in_i));
        if (seq.size() > PAT_W - 1) void'(seq.pop_front());
      end
    end
    if (cnt_clr) m_cnt = 0;
    else if (d && m_cnt < CNT_MAX) m_cnt++;
  endfunction

  task automatic cycle(input logic v, input logic b, input logic o, input logic l,
                       input logic [3:0] p, input logic c, input logic r);
    in_valid = v; in_i = b; overlap_en = o; pat_load = l; pat_i = p;
    cnt_clr = c; rst = r;
    @(negedge clk);
    obs_det = detect;
    exp_det = model_detect();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send_bit(input logic b, input logic o);
    cycle(1'b1, b, o, 1'b0, 4'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'b0, 1'b0, 1'b1);
    n_run++;
    if (obs_det !== 1'b0) begin
      n_fail++; $display("FAIL reset_detect: got %b want 0", obs_det);
    end
    do_reset();
    n_run++;
    if (fill_o !== 2'd0) begin n_fail++; $display("FAIL reset_fill: got %0d want 0", fill_o); end
    n_run++;
    if (match_count !== 3'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d want 0", match_count);
    end
  endtask

  task automatic test_stream_word();
    logic [31:0] word, hits_obs, hits_exp;
    logic [3:0]  win;
    word = 32'hFDCAE398;
    hits_exp = '0; hits_obs = '0; win = '0;
    for (int i = 0; i < 32; i++) begin
      win = {win[2:0], word[31-i]};
      if (i >= 3 && win == 4'b1011) hits_exp[i] = 1'b1;
    end
    do_reset();
    for (int i = 0; i < 32; i++) begin
      send_bit(word[31-i], 1'b1);
      hits_obs[i] = obs_det;
    end
    n_run++;
    if (hits_obs !== hits_exp) begin
      n_fail++; $display("FAIL word_hits: got %h want %h", hits_obs, hits_exp);
    end
    n_run++;
    if (match_count !== 3'd2) begin
      n_fail++; $display("FAIL word_count: got %0d want 2", match_count);
    end
  endtask

  task automatic test_overlap();
    logic [6:0] bits, hits;
    bits = 7'b1011011;
    do_reset();
    hits = '0;
    for (int i = 0; i < 7; i++) begin send_bit(bits[6-i], 1'b1); hits[i] = obs_det; end
    n_run++;
    if (hits !== 7'b1001000) begin n_fail++; $display("FAIL ovl_hits: got %b want 1001000", hits); end
    n_run++;
    if (match_count !== 3'd2) begin n_fail++; $display("FAIL ovl_count: got %0d want 2", match_count); end
    do_reset();
    hits = '0;
    for (int i = 0; i < 7; i++) begin send_bit(bits[6-i], 1'b0); hits[i] = obs_det; end
    n_run++;
    if (hits !== 7'b0001000) begin n_fail++; $display("FAIL novl_hits: got %b want 0001000", hits); end
    n_run++;
    if (match_count !== 3'd1) begin n_fail++; $display("FAIL novl_count: got %0d want 1", match_count); end
    n_run++;
    if (fill_o !== 2'd3) begin n_fail++; $display("FAIL novl_fill: got %0d want 3", fill_o); end
  endtask

  task automatic test_gaps();
    logic [3:0] bits;
    int gap_hits;
    bits = 4'b1011;
    gap_hits = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_bit(bits[3-i], 1'b1);
      if (i < 3) begin
        n_run++;
        if (obs_det !== 1'b0) begin n_fail++; $display("FAIL gap_early: bit %0d got %b want 0", i, obs_det); end
        for (int g = 0; g < 3; g++) begin idle(); if (obs_det !== 1'b0) gap_hits++; end
      end else begin
        n_run++;
        if (obs_det !== 1'b1) begin n_fail++; $display("FAIL gap_final: got %b want 1", obs_det); end
      end
    end
    idle();
    if (obs_det !== 1'b0) gap_hits++;
    n_run++;
    if (gap_hits != 0) begin n_fail++; $display("FAIL gap_idle: got %0d hits want 0", gap_hits); end
    n_run++;
    if (match_count !== 3'd1) begin n_fail++; $display("FAIL gap_count: got %0d want 1", match_count); end
  endtask

  task automatic test_pat_load();
    logic [3:0] post;
    logic [3:0] hits;
    post = 4'b0110;
    do_reset();
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0);
    n_run++;
    if (obs_det !== 1'b0) begin n_fail++; $display("FAIL load_drop: got %b want 0", obs_det); end
    n_run++;
    if (fill_o !== 2'd0) begin n_fail++; $display("FAIL load_fill: got %0d want 0", fill_o); end
    hits = '0;
    for (int i = 0; i < 4; i++) begin send_bit(post[3-i], 1'b1); hits[i] = obs_det; end
    n_run++;
    if (hits !== 4'b1000) begin n_fail++; $display("FAIL load_hits: got %b want 1000", hits); end
    n_run++;
    if (match_count !== 3'd1) begin n_fail++; $display("FAIL load_count: got %0d want 1", match_count); end
  endtask

  task automatic test_saturate();
    logic [3:0] bits;
    bits = 4'b1011;
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      for (int i = 0; i < 4; i++) send_bit(bits[3-i], 1'b0);
      n_run++;
      if (obs_det !== 1'b1) begin n_fail++; $display("FAIL sat_detect%0d: got %b want 1", k, obs_det); end
      n_run++;
      if (int'(match_count) != ((k < 7) ? k : 7)) begin
        n_fail++; $display("FAIL sat_count%0d: got %0d want %0d", k, match_count, (k < 7) ? k : 7);
      end
    end
    for (int i = 0; i < 3; i++) send_bit(bits[3-i], 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'b0, 1'b1, 1'b0);
    n_run++;
    if (obs_det !== 1'b1) begin n_fail++; $display("FAIL clr_detect: got %b want 1", obs_det); end
    n_run++;
    if (match_count !== 3'd0) begin n_fail++; $display("FAIL clr_count: got %0d want 0", match_count); end
  endtask

  task automatic test_mid_reset();
    logic [3:0] a, b;
    logic [3:0] hits;
    a = 4'b1100; b = 4'b1011;
    do_reset();
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'b1100, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(a[3-i], 1'b1);
    n_run++;
    if (match_count !== 3'd1) begin n_fail++; $display("FAIL mrst_pre_count: got %0d want 1", match_count); end
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'b0, 1'b0, 1'b1);
    n_run++;
    if (fill_o !== 2'd0) begin n_fail++; $display("FAIL mrst_fill: got %0d want 0", fill_o); end
    n_run++;
    if (match_count !== 3'd0) begin n_fail++; $display("FAIL mrst_count: got %0d want 0", match_count); end
    hits = '0;
    for (int i = 0; i < 4; i++) begin send_bit(b[3-i], 1'b1); hits[i] = obs_det; end
    n_run++;
    if (hits !== 4'b1000) begin n_fail++; $display("FAIL mrst_hits: got %b want 1000", hits); end
  endtask

  task automatic test_random();
    int bad_det, bad_fill, bad_cnt;
    logic r, l, c, v, b, o;
    logic [3:0] p;
    bad_det = 0; bad_fill = 0; bad_cnt = 0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(199) == 0);
      l = ($urandom_range(39) == 0);
      c = ($urandom_range(49) == 0);
      v = ($urandom_range(3) != 0);
      b = 1'($urandom_range(1));
      o = 1'($urandom_range(1));
      p = 4'($urandom_range(15));
      cycle(v, b, o, l, p, c, r);
      if (obs_det !== exp_det) begin
        bad_det++;
        if (bad_det < 5) $display("FAIL rnd_detect@%0d: got %b want %b", n, obs_det, exp_det);
      end
      if (fill_o !== 2'(seq.size())) begin
        bad_fill++;
        if (bad_fill < 5) $display("FAIL rnd_fill@%0d: got %0d want %0d", n, fill_o, seq.size());
      end
      if (match_count !== 3'(m_cnt)) begin
        bad_cnt++;
        if (bad_cnt < 5) $display("FAIL rnd_count@%0d: got %0d want %0d", n, match_count, m_cnt);
      end
    end
    n_run++;
    if (bad_det != 0) begin n_fail++; $display("FAIL rnd_detect_total: got %0d errors want 0", bad_det); end
    n_run++;
    if (bad_fill != 0) begin n_fail++; $display("FAIL rnd_fill_total: got %0d errors want 0", bad_fill); end
    n_run++;
    if (bad_cnt != 0) begin n_fail++; $display("FAIL rnd_count_total: got %0d errors want 0", bad_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_i = 1'b0; overlap_en = 1'b1;
    pat_load = 1'b0; pat_i = '0; cnt_clr = 1'b0;
    test_reset();
    test_stream_word();
    test_overlap();
    test_gaps();
    test_pat_load();
    test_saturate();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
